// File: rtl/montgomery_inv_param.sv
// rtl/montgomery_inv_param.sv - parametrised Kaliski modular inverse, plain or Montgomery form
// One almost-inverse iteration per clock, then a halving/doubling pass to remove or set the 2^k factor.
module montgomery_inv_param #(
  parameter int            W = 255,
  parameter logic [W-1:0]  P = {W{1'b1}} - W'(18)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic         i_mode,
  output logic [W-1:0] o_montgomeryInv,
  output logic         o_finished,
  output logic         o_busy,
  output logic         o_error
);

  localparam int            KW    = $clog2(2*W+1);
  localparam logic [KW-1:0] TWO_W = KW'(2*W);
  localparam logic [W:0]    PE    = {1'b0, P};

  generate
    if (!(P[0] && P[W-1])) begin : g_bad_modulus
      $error("montgomery_inv_param: P must be odd with 2^(W-1) < P < 2^W");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD, PH1, FIX, PH2, DONE} state_t;

  state_t        state;
  logic [W-1:0]  x_q, u, v;
  logic          mode_q, err_q;
  logic [W:0]    r, s;
  logic [KW-1:0] k, c;

  logic [W-1:0]  a_red;
  logic [W:0]    r_red, r_fix, r_half, r_dbl, r_dbl_red;
  logic [KW-1:0] c_load;

  // x < 2^W < 2P, so a single conditional subtract fully reduces it
  always_comb begin
    a_red     = (x_q >= P) ? x_q - P : x_q;
    r_red     = (r >= PE) ? r - PE : r;
    r_fix     = PE - r_red;
    r_half    = r[0] ? ((r + PE) >> 1) : (r >> 1);
    r_dbl     = r << 1;
    r_dbl_red = (r_dbl >= PE) ? r_dbl - PE : r_dbl;
    c_load    = mode_q ? TWO_W - k : k;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      o_montgomeryInv <= '0;
      o_finished      <= 1'b0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
      err_q           <= 1'b0;
      mode_q          <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      case (state)
        IDLE: begin
          o_busy <= i_start;
          if (i_start) begin
            x_q     <= i_x;
            mode_q  <= i_mode;
            o_error <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (a_red == '0) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            err_q <= 1'b0;
            u     <= P;
            v     <= a_red;
            r     <= '0;
            s     <= (W+1)'(1);
            k     <= '0;
            state <= PH1;
          end
        end
        PH1: begin
          k <= k + KW'(1);
          if (!u[0]) begin
            u <= u >> 1;
            s <= s << 1;
          end else if (!v[0]) begin
            v <= v >> 1;
            r <= r << 1;
          end else if (u > v) begin
            u <= (u - v) >> 1;
            r <= r + s;
            s <= s << 1;
          end else begin
            // v reaches zero only here, when u == v
            v <= (v - u) >> 1;
            s <= s + r;
            r <= r << 1;
            if (u == v) state <= FIX;
          end
        end
        FIX: begin
          r     <= r_fix;
          c     <= c_load;
          state <= (c_load == '0) ? DONE : PH2;
        end
        PH2: begin
          r <= mode_q ? r_dbl_red : r_half;
          c <= c - KW'(1);
          if (c == KW'(1)) state <= DONE;
        end
        DONE: begin
          o_montgomeryInv <= err_q ? '0 : r[W-1:0];
          o_error         <= err_q;
          o_finished      <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_inv_param.sv
// tb/tb_montgomery_inv_param.sv - randomized and exhaustive check of montgomery_inv_param
// Drives a W=8/P=251 instance and a default 255-bit instance against arithmetic reference models.
module tb_montgomery_inv_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, mode8, fin8, busy8, err8;
  logic [7:0] x8, res8;

  montgomery_inv_param #(.W(8), .P(8'd251)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_x(x8), .i_mode(mode8),
    .o_montgomeryInv(res8), .o_finished(fin8), .o_busy(busy8), .o_error(err8)
  );

  logic         rst_w, start_w, mode_w, fin_w, busy_w, err_w;
  logic [254:0] x_w, res_w;

  montgomery_inv_param dut_w (
    .i_clk(clk), .i_rst(rst_w), .i_start(start_w), .i_x(x_w), .i_mode(mode_w),
    .o_montgomeryInv(res_w), .o_finished(fin_w), .o_busy(busy_w), .o_error(err_w)
  );

  localparam logic [511:0] PW = (512'd1 << 255) - 512'd19;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic int inv8(input int a);
    for (int i = 1; i < 251; i++)
      if ((a * i) % 251 == 1) return i;
    return 0;
  endfunction

  function automatic int kal_k8(input int a);
    int uu = 251, vv = a, kk = 0;
    while (vv != 0 && kk < 100) begin
      if (uu % 2 == 0)      uu = uu / 2;
      else if (vv % 2 == 0) vv = vv / 2;
      else if (uu > vv)     uu = (uu - vv) / 2;
      else                  vv = (vv - uu) / 2;
      kk++;
    end
    return kk;
  endfunction

  function automatic int kal_kw(input logic [511:0] a);
    logic [511:0] uu = PW, vv = a;
    int kk = 0;
    while (vv != 0 && kk < 1000) begin
      if (!uu[0])       uu = uu >> 1;
      else if (!vv[0])  vv = vv >> 1;
      else if (uu > vv) uu = (uu - vv) >> 1;
      else              vv = (vv - uu) >> 1;
      kk++;
    end
    return kk;
  endfunction

  // Fermat: a^(P-2) mod P
  function automatic logic [511:0] inv_w(input logic [511:0] a);
    logic [511:0] res = 512'd1, base = a, e = PW - 512'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) res = (res * base) % PW;
      base = (base * base) % PW;
    end
    return res;
  endfunction

  // ---------------- W=8 drivers ----------------
  // Called at #1 after an edge while the DUT is in IDLE.
  task automatic run8(input int x, input bit mode, output int res, output int err,
                      output int lat, output int busy_ok);
    x8 = x[7:0]; mode8 = mode; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    busy_ok = (busy8 && !fin8) ? 1 : 0;
    while (!fin8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!busy8) busy_ok = 0;
    end
    if (!fin8) lat = -1;
    res = res8; err = err8;
  endtask

  task automatic do8(input int x, input bit mode, output int res);
    int err, lat, bok, a, eres, eerr, elat;
    run8(x, mode, res, err, lat, bok);
    a = x % 251;
    if (a == 0) begin eres = 0; eerr = 1; elat = 2; end
    else begin
      eerr = 0;
      eres = mode ? (inv8(a) * 65536) % 251 : inv8(a);
      elat = mode ? 19 : 3 + 2 * kal_k8(a);
    end
    check($sformatf("res8 x=%0d m=%0d", x, mode), res, eres);
    check($sformatf("err8 x=%0d m=%0d", x, mode), err, eerr);
    check($sformatf("lat8 x=%0d m=%0d", x, mode), lat, elat);
    check($sformatf("busy8 x=%0d m=%0d", x, mode), bok, 1);
  endtask

  // ---------------- W=255 driver ----------------
  task automatic dow(input logic [254:0] x, input bit mode, output logic [254:0] res);
    logic [511:0] a, eres, r2;
    int lat, bok, elat, eerr;
    x_w = x; mode_w = mode; start_w = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    lat = 0;
    bok = (busy_w && !fin_w) ? 1 : 0;
    while (!fin_w && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (!busy_w) bok = 0;
    end
    if (!fin_w) lat = -1;
    res = res_w;
    a = {257'd0, x};
    if (a >= PW) a = a - PW;
    r2 = (512'd1 << 510) % PW;
    if (a == 0) begin eres = 0; eerr = 1; elat = 2; end
    else begin
      eerr = 0;
      eres = inv_w(a);
      if (mode) eres = (eres * r2) % PW;
      elat = mode ? 3 + 510 : 3 + 2 * kal_kw(a);
    end
    check($sformatf("resw m=%0d", mode), {1'b0, res_w}, eres[255:0]);
    check($sformatf("errw m=%0d", mode), err_w, eerr);
    check($sformatf("latw m=%0d", mode), lat, elat);
    check($sformatf("busyw m=%0d", mode), bok, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int res, fins, n;
    logic [254:0] rw, xr;
    logic [255:0] t;

    rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; x8 = '0;
    rst_w = 1'b1; start_w = 1'b0; mode_w = 1'b0; x_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res8", res8, 0);
    check("reset fin8", fin8, 0);
    check("reset busy8", busy8, 0);
    check("reset err8", err8, 0);
    check("reset resw", res_w, 0);
    rst8 = 1'b0; rst_w = 1'b0;
    @(posedge clk); #1;

    // directed W=8 values
    do8(2, 0, res);   check("x2 m0 const", res, 126);
    @(posedge clk); #1;
    check("idle busy8", busy8, 0);
    check("idle fin8", fin8, 0);
    do8(252, 0, res); check("x252 m0 const", res, 1);
    do8(250, 0, res); check("x250 m0 const", res, 250);
    do8(10, 1, res);  check("x10 m1 const", res, 128);
    do8(1, 1, res);   check("x1 m1 const", res, 25);
    do8(0, 0, res);
    do8(251, 0, res);
    do8(0, 1, res);
    do8(251, 1, res);
    do8(3, 0, res);

    // start pulsed while busy is ignored
    x8 = 8'd2; mode8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    fins = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 5) begin x8 = 8'd7; start8 = 1'b1; end
      if (i == 6) start8 = 1'b0;
      @(posedge clk); #1;
      if (fin8) fins++;
    end
    check("ignore start fins", fins, 1);
    check("ignore start res", res8, 126);

    // reset in the middle of the almost-inverse phase
    x8 = 8'd5; mode8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check("midreset res8", res8, 0);
    check("midreset fin8", fin8, 0);
    check("midreset busy8", busy8, 0);
    check("midreset err8", err8, 0);
    fins = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fin8) fins++;
    end
    check("midreset no finish", fins, 0);
    do8(5, 0, res);

    // exhaustive, back-to-back
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 256; x++)
        do8(x, m[0], res);

    // random
    for (int i = 0; i < 200; i++)
      do8($urandom_range(0, 255), $urandom_range(0, 1), res);

    // default 255-bit instance
    dow(255'd2, 0, rw);
    check("w x2 const", {1'b0, rw}, (256'd1 << 254) - 256'd9);
    dow(255'd41122485346044635394807010149486965121812469313531572554546452885248451587758, 0, rw);
    dow(255'd2, 1, rw);
    dow(255'd0, 0, rw);
    xr = PW[254:0];
    dow(xr, 1, rw);
    for (int i = 0; i < 3; i++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      n = $urandom_range(0, 1);
      dow(t[254:0], n[0], rw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
